// File: rtl/usb_port_monitor.sv
// Per-port USB line-state monitor (bus reset, suspend/resume, SE1) plus device address staging.
// Suspend detection is built only when USB_SUSPEND_DETECT_EN is defined.
module usb_port_monitor #(
    parameter int NUM_PORTS      = 4,
    parameter int RESET_CYCLES   = 480_000,
    parameter int SUSPEND_CYCLES = 144_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NUM_PORTS-1:0] line_i,
    input  logic                   addr_stage_i,
    input  logic [6:0]             addr_i,
    input  logic                   addr_commit_i,
    output logic [2*NUM_PORTS-1:0] port_state_o,
    output logic [NUM_PORTS-1:0]   bus_reset_o,
    output logic [NUM_PORTS-1:0]   resume_o,
    output logic [NUM_PORTS-1:0]   se1_err_o,
    output logic [6:0]             dev_addr_o,
    output logic                   addr_valid_o
);
    localparam int MAXC = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] RST_MAX = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RST_HIT = CW'(RESET_CYCLES - 1);

    localparam logic [1:0] ST_ACTIVE = 2'b00;
    localparam logic [1:0] ST_RESET  = 2'b01;
    localparam logic [1:0] LN_SE0    = 2'b00;
    localparam logic [1:0] LN_K      = 2'b01;
    localparam logic [1:0] LN_J      = 2'b10;
    localparam logic [1:0] LN_SE1    = 2'b11;

    logic [NUM_PORTS-1:0][1:0]    state_q, state_d;
    logic [NUM_PORTS-1:0][CW-1:0] se0_q, se0_d;
    logic [NUM_PORTS-1:0]         bus_reset_q, bus_reset_d;
    logic [NUM_PORTS-1:0]         se1_err_q, se1_err_d;
    logic [6:0]                   pend_q, pend_d;
    logic                         pend_vld_q, pend_vld_d;
    logic [6:0]                   dev_addr_q, dev_addr_d;

`ifdef USB_SUSPEND_DETECT_EN
    localparam logic [1:0]    ST_SUSP = 2'b10;
    localparam logic [CW-1:0] SUS_MAX = CW'(SUSPEND_CYCLES);
    localparam logic [CW-1:0] SUS_HIT = CW'(SUSPEND_CYCLES - 1);
    logic [NUM_PORTS-1:0][CW-1:0] j_q, j_d;
    logic [NUM_PORTS-1:0]         resume_q, resume_d;
    logic [NUM_PORTS-1:0]         sus_hit;
`endif

    // Output process: per-port event detection feeding the pulse registers
    always_comb begin
        bus_reset_d = '0;
        se1_err_d   = '0;
`ifdef USB_SUSPEND_DETECT_EN
        resume_d    = '0;
        sus_hit     = '0;
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus_reset_d[p] = (line_i[2*p +: 2] == LN_SE0) && (se0_q[p] == RST_HIT);
            se1_err_d[p]   = (line_i[2*p +: 2] == LN_SE1);
`ifdef USB_SUSPEND_DETECT_EN
            resume_d[p] = (line_i[2*p +: 2] == LN_K) && (state_q[p] == ST_SUSP);
            sus_hit[p]  = (line_i[2*p +: 2] == LN_J) && (state_q[p] == ST_ACTIVE)
                          && (j_q[p] == SUS_HIT);
`endif
        end
    end

    // Next-state process
    always_comb begin
        state_d = state_q;
        se0_d   = se0_q;
`ifdef USB_SUSPEND_DETECT_EN
        j_d     = j_q;
`endif
        for (int p = 0; p < NUM_PORTS; p++) begin
            unique case (line_i[2*p +: 2])
                LN_SE0: begin
                    if (se0_q[p] != RST_MAX) se0_d[p] = se0_q[p] + 1'b1;
`ifdef USB_SUSPEND_DETECT_EN
                    j_d[p] = '0;
`endif
                    if (bus_reset_d[p]) state_d[p] = ST_RESET;
                end
                LN_J: begin
                    se0_d[p] = '0;
                    if (state_q[p] == ST_RESET) begin
                        state_d[p] = ST_ACTIVE;
`ifdef USB_SUSPEND_DETECT_EN
                        j_d[p] = '0;
                    end else begin
                        if (j_q[p] != SUS_MAX) j_d[p] = j_q[p] + 1'b1;
                        if (sus_hit[p]) state_d[p] = ST_SUSP;
`endif
                    end
                end
                LN_K: begin
                    se0_d[p] = '0;
`ifdef USB_SUSPEND_DETECT_EN
                    j_d[p] = '0;
                    if (resume_d[p]) state_d[p] = ST_ACTIVE;
`endif
                    if (state_q[p] == ST_RESET) state_d[p] = ST_ACTIVE;
                end
                LN_SE1: begin
                    se0_d[p] = '0;
`ifdef USB_SUSPEND_DETECT_EN
                    j_d[p] = '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Port 0 reset wins over any simultaneous stage/commit
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dev_addr_d = dev_addr_q;
        if (bus_reset_d[0]) begin
            pend_d     = '0;
            pend_vld_d = 1'b0;
            dev_addr_d = '0;
        end else if (addr_commit_i && addr_stage_i) begin
            dev_addr_d = addr_i;
            pend_vld_d = 1'b0;
        end else if (addr_commit_i && pend_vld_q) begin
            dev_addr_d = pend_q;
            pend_vld_d = 1'b0;
        end else if (addr_stage_i) begin
            pend_d     = addr_i;
            pend_vld_d = 1'b1;
        end
    end

    // State register process
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= '0;
            se0_q       <= '0;
            bus_reset_q <= '0;
            se1_err_q   <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            dev_addr_q  <= '0;
`ifdef USB_SUSPEND_DETECT_EN
            j_q         <= '0;
            resume_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            se0_q       <= se0_d;
            bus_reset_q <= bus_reset_d;
            se1_err_q   <= se1_err_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            dev_addr_q  <= dev_addr_d;
`ifdef USB_SUSPEND_DETECT_EN
            j_q         <= j_d;
            resume_q    <= resume_d;
`endif
        end
    end

    assign port_state_o = state_q;
    assign bus_reset_o  = bus_reset_q;
    assign se1_err_o    = se1_err_q;
    assign dev_addr_o   = dev_addr_q;
    assign addr_valid_o = (dev_addr_q != 7'd0);
`ifdef USB_SUSPEND_DETECT_EN
    assign resume_o = resume_q;
`else
    assign resume_o = '0;
`endif

endmodule
